// File: rtl/mag_cmp_seq.sv
// -----------------------------------------------------------------------------
// mag_cmp_seq
//   Sequential magnitude comparator. Compares two WIDTH-bit operands CHUNK bits
//   per cycle, most-significant chunk first, in unsigned or two's-complement
//   mode. Uses a start/busy/done handshake.
//
//   Optional feature (compile-time macro MAG_CMP_EARLY_EXIT_EN):
//     defined   - RUN ends at the first differing chunk (latency 1..NCHUNK)
//     undefined - RUN always walks all NCHUNK chunks (constant-time compare)
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        compare request, sampled only in IDLE
//   a, b         operands, captured on the accepted start
//   signed_mode  1 = two's-complement, 0 = unsigned; captured with operands
//   busy         high while a compare is running (RUN state)
//   done         one-cycle pulse; results are valid from this cycle
//   equal        A == B  (held until the next done)
//   greater      A >  B  (held until the next done)
//   lower        A <  B  (held until the next done)
// -----------------------------------------------------------------------------
module mag_cmp_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             greater,
  output logic             lower
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;

  // Captured operands are pure data: no reset needed.
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             smode_p0;

  logic             dec_gt;
  logic             dec_lt;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic             new_gt;
  logic             new_lt;
  logic             last;
  logic             finish;

  // Flipping the sign bit of the top chunk maps two's-complement ordering onto
  // unsigned ordering; lower chunks are plain magnitude bits in either mode.
  function automatic logic [CHUNK-1:0] chunk_key(
    input logic [CHUNK-1:0] c,
    input logic             flip_msb
  );
    logic [CHUNK-1:0] k;
    k = c;
    if (flip_msb) k[CHUNK-1] = ~c[CHUNK-1];
    return k;
  endfunction

  always_comb begin
    ca     = chunk_key(a_p0[idx*CHUNK +: CHUNK], smode_p0 && (idx == IDX_TOP));
    cb     = chunk_key(b_p0[idx*CHUNK +: CHUNK], smode_p0 && (idx == IDX_TOP));
    // The first decision sticks; lower chunks only decide when nothing has yet.
    new_gt = dec_gt | (~dec_gt & ~dec_lt & (ca > cb));
    new_lt = dec_lt | (~dec_gt & ~dec_lt & (ca < cb));
    last   = (idx == '0);
`ifdef MAG_CMP_EARLY_EXIT_EN
    finish = last | new_gt | new_lt;
`else
    finish = last;
`endif
  end

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (finish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- operand capture (stage p0) ----
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_p0     <= a;
      b_p0     <= b;
      smode_p0 <= signed_mode;
    end
  end

  // ---- chunk walk, decision and result registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      dec_gt  <= 1'b0;
      dec_lt  <= 1'b0;
      equal   <= 1'b0;
      greater <= 1'b0;
      lower   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx    <= IDX_TOP;
            dec_gt <= 1'b0;
            dec_lt <= 1'b0;
          end
        end
        RUN: begin
          dec_gt <= new_gt;
          dec_lt <= new_lt;
          if (finish) begin
            // Results land together with the entry into DONE so they are
            // valid in the same cycle as the done pulse.
            equal   <= ~(new_gt | new_lt);
            greater <= new_gt;
            lower   <= new_lt;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mag_cmp_seq.sv
module tb_mag_cmp_seq;

  localparam int W  = 16;
  localparam int CW = 4;
  localparam int NC = W / CW;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         signed_mode;
  logic         busy;
  logic         done;
  logic         equal;
  logic         greater;
  logic         lower;

  int n_chk = 0;
  int n_err = 0;

  logic [2:0] prev_res;   // {equal, greater, lower} last produced

  always #5 clk = ~clk;

  mag_cmp_seq #(.WIDTH(W), .CHUNK(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .equal       (equal),
    .greater     (greater),
    .lower       (lower)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width compare with plain arithmetic.
  function automatic logic [2:0] ref_res(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic sm);
    logic gt, lt;
    if (sm) begin
      gt = $signed(av) > $signed(bv);
      lt = $signed(av) < $signed(bv);
    end else begin
      gt = av > bv;
      lt = av < bv;
    end
    return {~(gt | lt), gt, lt};
  endfunction

  // Reference latency: position (from the top, 1-based) of first differing chunk.
  function automatic int ref_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
`ifdef MAG_CMP_EARLY_EXIT_EN
    for (int k = 1; k <= NC; k++) begin
      if (av[(NC-k)*CW +: CW] != bv[(NC-k)*CW +: CW]) return k;
    end
`endif
    return NC;
  endfunction

  task automatic run_cmp(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sm, input bit poke);
    logic [2:0] exp_res;
    int         exp_lat;
    int         cyc;
    exp_res = ref_res(av, bv, sm);
    exp_lat = ref_lat(av, bv);
    @(negedge clk);
    a = av; b = bv; signed_mode = sm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("hold_run", {29'd0, equal, greater, lower}, {29'd0, prev_res});
      if (poke && cyc == 0) begin
        start = 1'b1; a = ~av; b = av ^ 16'h8001; signed_mode = ~sm;
      end else if (poke && cyc == 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", cyc, exp_lat);
    chk("done", {31'd0, done}, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("result", {29'd0, equal, greater, lower}, {29'd0, exp_res});
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("result_hold", {29'd0, equal, greater, lower}, {29'd0, exp_res});
    prev_res = exp_res;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    prev_res = 3'b000;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", {29'd0, equal, greater, lower}, 32'd0);
    rst_n = 1'b1;

    // Directed cases
    run_cmp(16'h1234, 16'h1234, 1'b0, 1'b0);  // equal
    run_cmp(16'h8000, 16'h7FFF, 1'b0, 1'b0);  // top chunk, unsigned greater
    run_cmp(16'h8000, 16'h7FFF, 1'b1, 1'b0);  // top chunk, signed lower
    run_cmp(16'h1233, 16'h1234, 1'b0, 1'b0);  // last chunk lower
    run_cmp(16'hFFFF, 16'h0001, 1'b1, 1'b0);  // -1 < 1
    run_cmp(16'h1234, 16'h0234, 1'b0, 1'b1);  // start poked during RUN
    run_cmp(16'h0FFF, 16'h0FFF, 1'b1, 1'b1);  // equal after greater: hold + poke
    run_cmp(16'h7FFF, 16'h8000, 1'b1, 1'b0);  // signed max > min

    // Reset mid-compare
    @(negedge clk);
    a = 16'h5555; b = 16'h5555; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_res", {29'd0, equal, greater, lower}, 32'd0);
    rst_n = 1'b1;
    prev_res = 3'b000;
    run_cmp(16'hA000, 16'hA001, 1'b0, 1'b0);

    // Randomized compares with shared chunks to spread latencies
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] av, bv;
      av = W'($urandom);
      bv = av;
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 2) == 0) bv[c*CW +: CW] = CW'($urandom);
      end
      run_cmp(av, bv, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mag_cmp_seq.md
# mag_cmp_seq

Parametrised sequential magnitude comparator, the multi-bit successor to the team's 1-bit equal/greater/lower comparator. It compares two WIDTH-bit operands CHUNK bits per cycle, most-significant chunk first, with selectable signed or unsigned mode. It uses a start/busy/done handshake. It sits in datapaths where a full-width single-cycle compare would limit timing, such as sorters, threshold checkers and min/max trackers.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK, ≥ 2.
- CHUNK, 4, bits compared per cycle; NCHUNK = WIDTH/CHUNK.
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  request a compare; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with operands.
- busy  output  1  high while a compare is in progress (RUN state).
- done  output  1  one-cycle pulse; result outputs are valid from this cycle.
- equal  output  1  A == B.
- greater  output  1  A > B.
- lower  output  1  A < B.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- **IDLE:**
  - If start=1: latch a, b and signed_mode; set idx = NCHUNK-1; go to RUN.
  - Otherwise remain in IDLE.
- **RUN:** each cycle, compare chunk[idx] of A against chunk[idx] of B as unsigned CHUNK-bit values.
  - Signed mode: for the top chunk (idx = NCHUNK-1) only, invert the MSB of both chunks before the compare.
  - Chunk A > chunk B with no prior decision: record decision greater.
  - Chunk A < chunk B with no prior decision: record decision lower.
  - Chunks equal: no new decision.
  - A recorded decision is never overwritten by a lower chunk.
  - Go to DONE when idx == 0, or when a decision is made and early exit is enabled. Otherwise decrement idx.
  - idx == 0 with no decision: result is equal.
- **DONE:**
  - Load equal/greater/lower from the decision; exactly one of the three is high.
  - done=1 for this cycle only.
  - Return to IDLE next cycle.
- Result outputs hold their last value until the next DONE. They do not clear on start.
- start is ignored in RUN and DONE. There is no queuing.
- Changes on a, b and signed_mode after capture have no effect on the compare in progress.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE, idx=0, busy=0, done=0, equal=0, greater=0, lower=0, internal decision cleared.
- Reset mid-operation aborts the compare. No done is produced, and outputs go to their reset values.
- Start accepted at edge E0: busy=1 from E0.
- Chunk evaluation: chunk NCHUNK-k is evaluated at edge Ek.
- Decisive evaluation at edge Ej moves the FSM to DONE:
  - done=1 and the results update in the cycle after Ej.
  - busy=0 in that same cycle.
- Latency from start sample to done:
  - With early exit: j cycles, where j is the index of the first differing chunk counted from the top. Minimum is 1.
  - Without early exit: always NCHUNK cycles.
- Throughput: the next start is accepted in IDLE, at the earliest one cycle after done.

## Configuration
- Macro: MAG_CMP_EARLY_EXIT_EN.
- **Defined:** RUN leaves to DONE at the first differing chunk. Latency is data-dependent, from 1 to NCHUNK cycles.
- **Undefined:** RUN always walks all NCHUNK chunks. Latency is fixed at NCHUNK cycles and is data-independent, which gives constant-time compares. Results are identical in both builds.

## Test plan
Bench runs with WIDTH=16 and CHUNK=4 (NCHUNK=4).
- **Equal operands:** a=0x1234, b=0x1234, unsigned, start at E0 → done=1 after E4; equal=1, greater=0, lower=0; same timing in both builds.
- **Top-chunk difference:** a=0x8000, b=0x7FFF.
  - Unsigned → greater=1; done after E1 with the macro, after E4 without.
  - Signed, same operands → lower=1.
- **Last-chunk difference:** a=0x1233, b=0x1234, unsigned → lower=1, done after E4 in both builds; a=0xFFFF vs b=0x0001 signed → lower=1.
- **Busy handling:** start pulsed during RUN with different operands → ignored; done pulses exactly once with the original result; busy=1 for exactly the latency cycles.
- **Reset mid-compare:** rst_n=0 after E2 of a compare → next cycle busy=0, done=0, equal=greater=lower=0, state IDLE; a fresh start then completes normally.
- **Result hold:** after a greater result, start a new compare → greater stays 1 until the new done. The new result (e.g. equal) then appears with the done pulse, one-hot.
